// File: rtl/motor_speed_sequencer_if.sv
// Push-button inputs and speed-selector outputs of the motor speed sequencer.
// The DUT connects through the slave modport; the button driver uses master.
interface motor_speed_sequencer_if;
   logic       Btn_up_i;
   logic       Btn_dn_i;
   logic       Btn_stop_i;
   logic [1:0] Sel_o;
   logic [1:0] Target_o;
   logic       Busy_o;

   modport master (
      output Btn_up_i, Btn_dn_i, Btn_stop_i,
      input  Sel_o, Target_o, Busy_o
   );

   modport slave (
      input  Btn_up_i, Btn_dn_i, Btn_stop_i,
      output Sel_o, Target_o, Busy_o
   );
endinterface

// File: rtl/motor_speed_sequencer.sv
// Debounced up/down/stop buttons set a target speed level; the PWM selector
// ramps toward it one level per RAMP_CYCLES, stop forces everything to zero.
module motor_speed_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
   parameter int unsigned RAMP_CYCLES     = 32'd25000000
) (
   input  logic                   Clk_i,
   input  logic                   Reset_i,
   motor_speed_sequencer_if.slave bus
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
   localparam int unsigned RT_W = (RAMP_CYCLES > 32'd1) ? $clog2(RAMP_CYCLES) : 32'd1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [RT_W-1:0] RT_LAST = RT_W'(RAMP_CYCLES - 32'd1);
   localparam int BTN_UP   = 0;
   localparam int BTN_DN   = 1;
   localparam int BTN_STOP = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RAMP_UP = 2'd1,
      ST_RAMP_DN = 2'd2
   } ramp_state_e;

   function automatic logic [1:0] sat_inc(input logic [1:0] lvl);
      if (lvl == 2'd3) begin
         return 2'd3;
      end else begin
         return lvl + 2'd1;
      end
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] lvl);
      if (lvl == 2'd0) begin
         return 2'd0;
      end else begin
         return lvl - 2'd1;
      end
   endfunction

   function automatic ramp_state_e ramp_dir(input logic [1:0] sel, input logic [1:0] tgt);
      if (sel == tgt) begin
         return ST_IDLE;
      end else if (sel < tgt) begin
         return ST_RAMP_UP;
      end else begin
         return ST_RAMP_DN;
      end
   endfunction

   logic [2:0]      btn_raw_s;
   logic [2:0]      sync1_r;
   logic [2:0]      sync2_r;
   logic [1:0]      sync_vld_r;
   logic [2:0]      deb_r;
   logic [2:0]      armed_r;
   logic [2:0]      press_r;
   logic [DB_W-1:0] db_cnt_r [3];
   logic [2:0]      deb_nxt_s;
   logic [2:0]      armed_nxt_s;
   logic [2:0]      press_nxt_s;
   logic [DB_W-1:0] db_cnt_nxt_s [3];

   logic            up_p_s;
   logic            dn_p_s;
   logic            stop_p_s;
   logic [1:0]      target_r;
   logic [1:0]      target_nxt_s;
   logic [1:0]      sel_r;
   logic [1:0]      sel_nxt_s;
   logic            busy_r;
   logic            busy_nxt_s;
   logic [RT_W-1:0] timer_r;
   logic [RT_W-1:0] timer_nxt_s;
   ramp_state_e     state_r;
   ramp_state_e     state_nxt_s;
   ramp_state_e     dir_s;

   assign btn_raw_s = {bus.Btn_stop_i, bus.Btn_dn_i, bus.Btn_up_i};

   // Two-flop synchronisers; sync_vld_r marks when sync2_r holds a real sample.
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         sync1_r    <= 3'b000;
         sync2_r    <= 3'b000;
         sync_vld_r <= 2'b00;
      end else begin
         sync1_r    <= btn_raw_s;
         sync2_r    <= sync1_r;
         sync_vld_r <= {sync_vld_r[0], 1'b1};
      end
   end

   // Per-button debounce; a press is only accepted once the button was seen released
   // after reset, so a button held through reset cannot issue a command.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         db_cnt_nxt_s[i] = db_cnt_r[i];
         deb_nxt_s[i]    = deb_r[i];
         press_nxt_s[i]  = 1'b0;
         armed_nxt_s[i]  = armed_r[i] | (sync_vld_r[1] & ~sync2_r[i] & ~deb_r[i]);
         if (sync2_r[i] == deb_r[i]) begin
            db_cnt_nxt_s[i] = {DB_W{1'b0}};
         end else if (db_cnt_r[i] == DB_LAST) begin
            db_cnt_nxt_s[i] = {DB_W{1'b0}};
            deb_nxt_s[i]    = sync2_r[i];
            press_nxt_s[i]  = sync2_r[i] & armed_r[i];
         end else begin
            db_cnt_nxt_s[i] = db_cnt_r[i] + DB_W'(1'b1);
         end
      end
   end

   // Debounce state and press-pulse registers.
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         deb_r   <= 3'b000;
         armed_r <= 3'b000;
         press_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= {DB_W{1'b0}};
         end
      end else begin
         deb_r   <= deb_nxt_s;
         armed_r <= armed_nxt_s;
         press_r <= press_nxt_s;
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= db_cnt_nxt_s[i];
         end
      end
   end

   assign up_p_s   = press_r[BTN_UP];
   assign dn_p_s   = press_r[BTN_DN];
   assign stop_p_s = press_r[BTN_STOP];
   assign dir_s    = ramp_dir(sel_r, target_r);

   // Target level update: stop wins, simultaneous up+down cancel.
   always_comb begin
      target_nxt_s = target_r;
      if (stop_p_s) begin
         target_nxt_s = 2'd0;
      end else if (up_p_s && !dn_p_s) begin
         target_nxt_s = sat_inc(target_r);
      end else if (dn_p_s && !up_p_s) begin
         target_nxt_s = sat_dec(target_r);
      end else begin
         target_nxt_s = target_r;
      end
   end

   // Ramp FSM next state, timer and selector; a reversal restarts the interval.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      sel_nxt_s   = sel_r;
      if (stop_p_s) begin
         state_nxt_s = ST_IDLE;
         timer_nxt_s = {RT_W{1'b0}};
         sel_nxt_s   = 2'd0;
      end else begin
         case (dir_s)
            ST_RAMP_UP, ST_RAMP_DN: begin
               state_nxt_s = dir_s;
               if ((state_r != ST_IDLE) && (state_r != dir_s)) begin
                  timer_nxt_s = {RT_W{1'b0}};
               end else if (timer_r == RT_LAST) begin
                  timer_nxt_s = {RT_W{1'b0}};
                  if (dir_s == ST_RAMP_UP) begin
                     sel_nxt_s = sel_r + 2'd1;
                  end else begin
                     sel_nxt_s = sel_r - 2'd1;
                  end
               end else begin
                  timer_nxt_s = timer_r + RT_W'(1'b1);
               end
            end
            ST_IDLE: begin
               state_nxt_s = ST_IDLE;
               timer_nxt_s = {RT_W{1'b0}};
            end
            default: begin
               state_nxt_s = ST_IDLE;
               timer_nxt_s = {RT_W{1'b0}};
            end
         endcase
      end
      busy_nxt_s = (sel_nxt_s != target_nxt_s);
   end

   // Ramp state, target and output registers.
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         state_r  <= ST_IDLE;
         timer_r  <= {RT_W{1'b0}};
         sel_r    <= 2'd0;
         target_r <= 2'd0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         timer_r  <= timer_nxt_s;
         sel_r    <= sel_nxt_s;
         target_r <= target_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   assign bus.Sel_o    = sel_r;
   assign bus.Target_o = target_r;
   assign bus.Busy_o   = busy_r;

endmodule
